dmac_master_mc: RTL
===================

# dmac_master_mc

Parametrised multi-channel AHB-Lite DMA master, the next generation of the single-channel DMAC engine. NCH independent channel contexts share one AHB-Lite master port through a round-robin arbiter that re-arbitrates at every block boundary. It adds an error abort on HRESP, a zero-count/illegal-size check, and corrected byte-lane alignment. Sits between the DMAC register file (per-channel config, flattened) and the system AHB-Lite bus.

## Interface
- NCH, 2: channel count (1..8).
- CW, 8: block-size and block-count width.
- NIRQ, 8: peripheral request lines; IW = clog2(NIRQ).
- HCLK  in  1  clock.
- HRESETn  in  1  reset HRESETn, asynchronous, active-low; clock HCLK.
- HADDR  out  32  / HTRANS  out  2  / HSIZE  out  3  / HWRITE  out  1  / HWDATA  out  32: AHB-Lite master outputs.
- HREADY  in  1  / HRDATA  in  32  / HRESP  in  1: AHB-Lite responses.
- saddr, daddr  in  NCH*32  per-channel source/destination base.
- ssize, dsize, sinc, dinc  in  NCH*3 each  transfer sizes (0 byte, 1 half, 2 word) and address increments (zero-extended).
- bsize, bcount  in  NCH*CW each  transfers per block, blocks per job.
- start, wfi  in  NCH each  job start pulse; pace transfers on peripheral request.
- irqsrc  in  NCH*IW  request select; pirq  in  NIRQ  peripheral requests.
- done, err, busy  out  NCH each  completion pulse, error pulse, job active.

## Operation
- start[k] while busy[k]=0: latch all channel-k config, SA=saddr, DA=daddr, CR=bcount; busy[k]=1. start[k] while busy[k]=1 ignored. Simultaneous starts on several channels all latched.
- Latched bsize=0 or bcount=0: no bus traffic, done[k] pulse; ssize or dsize >2: no bus traffic, err[k] pulse.
- Channel eligible = busy & not in-service & (~wfi | pirq[irqsrc]).
- Engine FSM: IDLE, RA, RD, WA, WD, NEXT, WFI.
- IDLE: any eligible → grant round-robin (lowest index after last grantee), CB=bsize → RA.
- RA: HTRANS=NONSEQ, HWRITE=0, HADDR=SA, HSIZE=ssize; HREADY=1 → RD.
- RD: HTRANS=IDLE; on HREADY=1 capture aligned HRDATA into D, SA+=sinc → WA.
- WA: HTRANS=NONSEQ, HWRITE=1, HADDR=DA, HSIZE=dsize; HREADY=1 → WD.
- WD: HTRANS=IDLE, HWDATA=D; on HREADY=1 DA+=dinc → NEXT.
- NEXT: CB-=1. CB now ≠0: → RA if request present else WFI. CB now 0: CR-=1; CR now 0 → done[k], busy[k]=0; → IDLE (re-arbitrate even if CR≠0).
- WFI: HTRANS=IDLE; → RA when request of granted channel present.
- HRESP=1 with HREADY=1 in RD or WD: transfer dropped, err[k] pulse, busy[k]=0, no further traffic for k, → IDLE.
- Alignment: ssize 2 → HRDATA; 1 → selected half (SA[1]) replicated ×2; 0 → selected byte (SA[1:0]) replicated ×4.
- Address arithmetic modulo 2^32; no alignment check on SA/DA.

## Timing
- Reset: HADDR=0, HTRANS=IDLE, HSIZE=0, HWRITE=0, HWDATA=0, done=err=busy=0, FSM IDLE, RR pointer at channel NCH-1 (channel 0 wins first).
- start sampled at edge t; busy[k]=1 from t+1; first RA at t+2 if engine idle and eligible.
- Zero-wait transfer: 5 cycles (RA, RD, WA, WD, NEXT); back-to-back transfers in a block have no gap.
- HTRANS/HADDR/HSIZE/HWRITE stable through HREADY-low address-phase stalls; HWDATA stable through data-phase stalls.
- done/err: registered one-cycle pulse in the cycle after NEXT/RD/WD; busy falls in the same cycle.
- HRESETn mid-job: all contexts cleared, HTRANS=IDLE immediately (asynchronous), no done/err.

## Structure
- Package dmac_pkg: FSM state encoding, HTRANS codes (IDLE=2'b00, NONSEQ=2'b10), HSIZE codes, lane-alignment function.
- Sub-module dmac_rr_arbiter (NCH-bit request in, one-hot grant out, pointer advanced on accept).
- Channel contexts held in arrays indexed by grant; config vectors sliced with indexed part-selects.

## Test plan
- ch0 saddr=0x100, daddr=0x200, word, sinc=dinc=4, bsize=2, bcount=1, wfi=0, start at edge 0 → reads 0x100/0x104, writes 0x200/0x204 with captured data; RA at cycles 2 and 7; done[0] at cycle 12.
- ch0 and ch1 started together, bsize=2, bcount=2 each → block order ch0, ch1, ch0, ch1; two done pulses, ch0 first.
- ssize=0, SA=0x103, HRDATA=0xAABBCCDD → D=0xAAAAAAAA; ssize=1, SA=0x102 → D=0xAABBAABB.
- wfi=1, irqsrc=3, pirq[3] held low 10 cycles → no NONSEQ; pirq[3] high → RA next cycle.
- HRESP=1 on second read of a 4-transfer block → err pulse, busy=0, no write for that transfer, other channel continues.
- bcount=0 → done next cycle, no bus traffic; dsize=3 → err, no bus traffic; HREADY low 3 cycles in WA → HADDR/HWRITE held, latency +3.

Source files
------------

// File: rtl/dmac_pkg.sv
// dmac_pkg: shared definitions for the multi-channel DMA master.
//   - engine FSM state encoding
//   - AHB-Lite HTRANS / HSIZE codes
//   - lane_align(): places the addressed byte or halfword of a read beat on
//     every lane, so the write side sees the same value on any lane.
package dmac_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RA   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WA   = 3'd3;
    localparam logic [2:0] S_WD   = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_WFI  = 3'd6;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // The addressed byte or halfword is replicated across the whole word.
    // A narrow write to any destination offset then picks up the right value
    // without a second shifter.
    function automatic logic [31:0] lane_align(input logic [31:0] rdata,
                                               input logic [2:0]  sz,
                                               input logic [1:0]  a);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? rdata[31:16] : rdata[15:0];
        b = rdata[{a, 3'b000} +: 8];
        case (sz)
            HSIZE_BYTE: return {4{b}};
            HSIZE_HALF: return {2{h}};
            default:    return rdata;
        endcase
    endfunction

endpackage

// File: rtl/dmac_master_mc_if.sv
// dmac_master_mc_if: AHB-Lite master port bundle.
//   master modport: drives HADDR/HTRANS/HSIZE/HWRITE/HWDATA and
//                   samples HREADY/HRDATA/HRESP.
//   slave modport:  the reverse directions.
interface dmac_master_mc_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
                    input  HREADY, HRDATA, HRESP);
    modport slave  (input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
                    output HREADY, HRDATA, HRESP);
endinterface

// File: rtl/dmac_rr_arbiter.sv
// dmac_rr_arbiter: round-robin arbiter.
//   req    in  N   requesting channels
//   accept in  1   grant is taken this cycle; the pointer moves to the winner
//   gnt    out N   one-hot grant (the lowest index after the last winner)
// After reset the pointer is N-1, so channel 0 wins the first arbitration.
module dmac_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = PW'(idx);
                found    = 1'b1;
            end
        end
        if (!accept) ptr_d = ptr_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) ptr_q <= PW'(N - 1);
        else          ptr_q <= ptr_d;
endmodule

// File: rtl/dmac_master_mc.sv
// dmac_master_mc: multi-channel AHB-Lite DMA master.
//   HCLK/HRESETn             clock and asynchronous active-low reset
//   bus (master)             shared AHB-Lite master port
//   saddr/daddr              per-channel base addresses (NCH*32)
//   ssize/dsize/sinc/dinc    per-channel sizes and increments (NCH*3)
//   bsize/bcount             transfers per block, blocks per job (NCH*CW)
//   start/wfi/irqsrc/pirq    job start, request pacing, request select
//   done/err/busy            per-channel completion, error, active
// One engine runs read/write pairs for the granted channel. The channel is
// re-arbitrated at every block boundary.
module dmac_master_mc
    import dmac_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int CW   = 8,
    parameter int NIRQ = 8,
    parameter int IW   = $clog2(NIRQ)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    dmac_master_mc_if.master  bus,
    input  logic [NCH*32-1:0] saddr,
    input  logic [NCH*32-1:0] daddr,
    input  logic [NCH*3-1:0]  ssize,
    input  logic [NCH*3-1:0]  dsize,
    input  logic [NCH*3-1:0]  sinc,
    input  logic [NCH*3-1:0]  dinc,
    input  logic [NCH*CW-1:0] bsize,
    input  logic [NCH*CW-1:0] bcount,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    wfi,
    input  logic [NCH*IW-1:0] irqsrc,
    input  logic [NIRQ-1:0]   pirq,
    output logic [NCH-1:0]    done,
    output logic [NCH-1:0]    err,
    output logic [NCH-1:0]    busy
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] g_q, g_d, gidx;
    logic [CW-1:0] cb_q, cb_d;
    logic [31:0]   dat_q, dat_d;
    logic [NCH-1:0] busy_q, busy_d, done_q, done_d, err_q, err_d, wf_q, wf_d;
    logic [NCH-1:0] req_ch, elig, arb_gnt;

    logic [31:0]   sa_q[NCH], sa_d[NCH], da_q[NCH], da_d[NCH];
    logic [CW-1:0] cr_q[NCH], cr_d[NCH], bs_q[NCH], bs_d[NCH];
    logic [2:0]    ss_q[NCH], ss_d[NCH], ds_q[NCH], ds_d[NCH];
    logic [2:0]    si_q[NCH], si_d[NCH], di_q[NCH], di_d[NCH];
    logic [IW-1:0] irq_q[NCH], irq_d[NCH];

    // Arbitration happens only in IDLE, when no channel is in service, so the
    // in-service exclusion reduces to gating the accept with IDLE.
    always_comb begin
        for (int k = 0; k < NCH; k++) req_ch[k] = ~wf_q[k] | pirq[irq_q[k]];
        elig = busy_q & req_ch;
        gidx = '0;
        for (int k = 0; k < NCH; k++) if (arb_gnt[k]) gidx = GW'(k);
    end

    dmac_rr_arbiter #(.N(NCH)) u_arb (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req     (elig),
        .accept  ((state_q == S_IDLE) && (|elig)),
        .gnt     (arb_gnt)
    );

    always_comb begin
        state_d = state_q; g_d = g_q; cb_d = cb_q; dat_d = dat_q;
        busy_d = busy_q; wf_d = wf_q; done_d = '0; err_d = '0;
        sa_d = sa_q; da_d = da_q; cr_d = cr_q; bs_d = bs_q;
        ss_d = ss_q; ds_d = ds_q; si_d = si_q; di_d = di_q; irq_d = irq_q;

        // Start on an idle channel latches its config. Illegal sizes and
        // empty jobs finish at once, and the channel never becomes busy.
        for (int k = 0; k < NCH; k++) begin
            if (start[k] && !busy_q[k]) begin
                sa_d[k]  = saddr[k*32 +: 32];  da_d[k] = daddr[k*32 +: 32];
                ss_d[k]  = ssize[k*3 +: 3];    ds_d[k] = dsize[k*3 +: 3];
                si_d[k]  = sinc[k*3 +: 3];     di_d[k] = dinc[k*3 +: 3];
                bs_d[k]  = bsize[k*CW +: CW];  cr_d[k] = bcount[k*CW +: CW];
                wf_d[k]  = wfi[k];             irq_d[k] = irqsrc[k*IW +: IW];
                if (ssize[k*3 +: 3] > HSIZE_WORD || dsize[k*3 +: 3] > HSIZE_WORD)
                    err_d[k] = 1'b1;
                else if (bsize[k*CW +: CW] == '0 || bcount[k*CW +: CW] == '0)
                    done_d[k] = 1'b1;
                else
                    busy_d[k] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: if (|elig) begin
                g_d = gidx; cb_d = bs_q[gidx]; state_d = S_RA;
            end
            S_RA: if (bus.HREADY) state_d = S_RD;
            S_RD: if (bus.HREADY) begin
                if (bus.HRESP) begin
                    err_d[g_q] = 1'b1; busy_d[g_q] = 1'b0; state_d = S_IDLE;
                end else begin
                    dat_d = lane_align(bus.HRDATA, ss_q[g_q], sa_q[g_q][1:0]);
                    sa_d[g_q] = sa_q[g_q] + {29'd0, si_q[g_q]};
                    state_d = S_WA;
                end
            end
            S_WA: if (bus.HREADY) state_d = S_WD;
            S_WD: if (bus.HREADY) begin
                if (bus.HRESP) begin
                    err_d[g_q] = 1'b1; busy_d[g_q] = 1'b0; state_d = S_IDLE;
                end else begin
                    da_d[g_q] = da_q[g_q] + {29'd0, di_q[g_q]};
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                cb_d = cb_q - CW'(1);
                if (cb_q != CW'(1)) begin
                    state_d = req_ch[g_q] ? S_RA : S_WFI;
                end else begin
                    cr_d[g_q] = cr_q[g_q] - CW'(1);
                    if (cr_q[g_q] == CW'(1)) begin
                        done_d[g_q] = 1'b1; busy_d[g_q] = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            S_WFI: if (req_ch[g_q]) state_d = S_RA;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs decode from registered state, so reset forces IDLE at once
    // and address and data phases hold through HREADY stalls.
    always_comb begin
        bus.HTRANS = HTRANS_IDLE; bus.HADDR = '0; bus.HSIZE = '0;
        bus.HWRITE = 1'b0;        bus.HWDATA = '0;
        case (state_q)
            S_RA: begin
                bus.HTRANS = HTRANS_NONSEQ; bus.HADDR = sa_q[g_q];
                bus.HSIZE  = ss_q[g_q];
            end
            S_WA: begin
                bus.HTRANS = HTRANS_NONSEQ; bus.HADDR = da_q[g_q];
                bus.HSIZE  = ds_q[g_q];     bus.HWRITE = 1'b1;
            end
            S_WD: bus.HWDATA = dat_q;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE; g_q <= '0; cb_q <= '0; dat_q <= '0;
            busy_q <= '0; done_q <= '0; err_q <= '0; wf_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                sa_q[k] <= '0; da_q[k] <= '0; cr_q[k] <= '0; bs_q[k] <= '0;
                ss_q[k] <= '0; ds_q[k] <= '0; si_q[k] <= '0; di_q[k] <= '0;
                irq_q[k] <= '0;
            end
        end else begin
            state_q <= state_d; g_q <= g_d; cb_q <= cb_d; dat_q <= dat_d;
            busy_q <= busy_d; done_q <= done_d; err_q <= err_d; wf_q <= wf_d;
            sa_q <= sa_d; da_q <= da_d; cr_q <= cr_d; bs_q <= bs_d;
            ss_q <= ss_d; ds_q <= ds_d; si_q <= si_d; di_q <= di_d;
            irq_q <= irq_d;
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;
endmodule
